output_argmax: RTL
==================

Name: output_argmax

Overview:
- Classification stage directly downstream of the final MLP layer.
- Captures the layer's parallel neuron-output vector when the layer signals valid.
- Scans the captured entries sequentially, one per cycle, to find the maximum.
- Presents the winning class index and its value with a valid/ready handshake to the host or result register.

Parameters:
NN, 10, number of neuron outputs (classes) in the vector; must be >= 1
dataWidth, 16, width of each neuron output
indexWidth, 4, width of the class index; must satisfy 2^indexWidth >= NN
isSigned, 1, 1 = compare entries as two's complement, 0 = compare as unsigned

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
i_valid  input  1  vector valid; driven from final layer o_valid[0]
i_data  input  NN*dataWidth  neuron outputs; entry k at [k*dataWidth +: dataWidth]
o_valid  output  1  result valid
o_ready  input  1  consumer accepts result
o_index  output  indexWidth  index of the maximum entry
o_maxValue  output  dataWidth  value of the maximum entry
busy  output  1  high whenever state != IDLE
drop  output  1  one-cycle pulse: an i_valid was ignored

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; o_valid=0, o_index=0, o_maxValue=0, busy=0, drop=0.
  - Capture buffer, scan counter and running max/index cleared.
  - Takes effect immediately, including mid-scan and while holding a result; the pending result is lost.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On i_valid=1, register all NN entries into the buffer.
  - maxVal <= entry0, maxIdx <= 0, cnt <= 1.
  - Go to SCAN; if NN==1, go directly to DONE.
- SCAN:
  - Each cycle compare buffer[cnt] against maxVal, signed or unsigned per isSigned.
  - Replace maxVal/maxIdx only if strictly greater; ties keep the lowest index.
  - cnt increments. After comparing entry NN-1, go to DONE.
- DONE:
  - o_valid=1; o_index and o_maxValue hold the result, stable until the handshake.
  - When o_valid & o_ready: o_valid falls next cycle and state returns to IDLE.
- Latency: i_valid accepted at edge T -> o_valid first high after edge T+NN (T+1 when NN==1). Throughput is one vector per NN+1 cycles when o_ready is held high.
- Back-to-back: in DONE, if o_ready=1 and i_valid=1 in the same cycle, the result is consumed and the new vector is captured in that cycle (state -> SCAN). No drop pulse, no idle bubble.
- Overflow: i_valid=1 while in SCAN, or in DONE with o_ready=0:
  - Input is ignored; buffer and result are unaffected.
  - drop pulses high for exactly one cycle per ignored cycle.
- Inputs are sampled only on the capture edge; i_data changes after capture have no effect.
- busy is registered and equals (state != IDLE).
- o_index and o_maxValue are registered outputs. They retain their last values when o_valid=0 (0 after reset).
- No combinational path from i_valid or i_data to any output. o_ready affects only the next state, never outputs in the same cycle.

Test Plan:
- Reset then basic: NN=10, isSigned=1, i_data entries {5,3,9,-2,0,1,7,9,4,8}, o_ready=1 -> o_valid high 10 cycles after capture, o_index=2 (tie with 7 resolves low), o_maxValue=9, one-cycle o_valid, busy low afterwards.
- Signed vs unsigned: all entries 0x0001 except entry 6 = 0xFFF0 -> isSigned=1 gives o_index=0, o_maxValue=0x0001; isSigned=0 gives o_index=6, o_maxValue=0xFFF0.
- Backpressure and drop: o_ready=0, vector with max at index 9 (value 0x0100) -> o_valid held with o_index=9 for 20 cycles. i_valid pulsed with a new vector during the scan and during the hold -> drop pulses once per pulse; result unchanged; on o_ready=1 it is consumed once.
- Back-to-back: o_ready=1; second vector (max at index 4) presented in the exact cycle the first result is consumed -> no drop; second o_valid exactly NN+1 cycles after the first; o_index=4.
- Async reset mid-scan: assert rst=0 four cycles after capture, between clock edges -> outputs zero immediately, state IDLE. After release, a new vector with max at index 1 yields o_index=1 with normal latency.
- NN=1 configuration: single entry 0x7FFF -> o_valid one cycle after capture, o_index=0, o_maxValue=0x7FFF.

Source files
------------

// File: rtl/output_argmax.sv
// output_argmax
// Classification stage behind the final MLP layer. When the layer signals
// valid, the whole neuron-output vector is captured into a buffer. The
// buffer is then walked one entry per cycle to find the maximum, and the
// winning class index and value are offered on a valid/ready handshake.
// Ties keep the lowest index. An i_valid that arrives while a vector is
// being scanned, or while a result is waiting, is ignored and reported on
// drop. When a result is consumed in the same cycle that a new vector
// arrives, the new vector is captured with no idle bubble.
module output_argmax #(
    parameter int NN         = 10,
    parameter int dataWidth  = 16,
    parameter int indexWidth = 4,
    parameter bit isSigned   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [NN*dataWidth-1:0]  i_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [indexWidth-1:0]    o_index,
    output logic [dataWidth-1:0]     o_maxValue,
    output logic                     busy,
    output logic                     drop
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the last entry; the scan ends after comparing this one.
    localparam logic [indexWidth-1:0] LAST_IDX = indexWidth'(NN - 1);

    state_t                 r_state;
    state_t                 w_state_next;

    // Capture buffer and running scan state.
    logic [dataWidth-1:0]   r_buf [NN];
    logic [dataWidth-1:0]   r_max;
    logic [indexWidth-1:0]  r_idx;
    logic [indexWidth-1:0]  r_cnt;

    // Registered outputs.
    logic                   r_valid;
    logic [indexWidth-1:0]  r_index;
    logic [dataWidth-1:0]   r_maxValue;
    logic                   r_busy;
    logic                   r_drop;

    // Decoded control and datapath wires.
    logic [dataWidth-1:0]   w_entry [NN];
    logic [dataWidth-1:0]   w_cand;
    logic                   w_greater;
    logic                   w_handshake;
    logic                   w_capture;
    logic                   w_ignore;

    // Split the flat input bus into one word per class.
    genvar gi;
    generate
        for (gi = 0; gi < NN; gi++) begin : g_unpack
            assign w_entry[gi] = i_data[gi*dataWidth +: dataWidth];
        end
    endgenerate

    // Entry currently under comparison.
    assign w_cand = r_buf[r_cnt];

    // Strictly-greater compare in the configured number format, so an
    // equal later entry never displaces an earlier winner.
    generate
        if (isSigned) begin : g_signed_cmp
            assign w_greater = $signed(w_cand) > $signed(r_max);
        end else begin : g_unsigned_cmp
            assign w_greater = w_cand > r_max;
        end
    endgenerate

    // Handshake, capture and overflow decode. A new vector is taken only
    // when the stage is idle or the pending result leaves in this cycle.
    always_comb begin
        w_handshake = 1'b0;
        w_capture   = 1'b0;
        w_ignore    = 1'b0;
        w_handshake = (r_state == DONE) && r_valid && o_ready;
        w_capture   = i_valid && ((r_state == IDLE) || w_handshake);
        w_ignore    = i_valid && !w_capture;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_next = (NN == 1) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (w_handshake) begin
                    if (w_capture) begin
                        w_state_next = (NN == 1) ? DONE : SCAN;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register; busy is registered alongside it so it tracks the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    // Capture the vector and run the sequential maximum search.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NN; k++) begin
                r_buf[k] <= '0;
            end
            r_max <= '0;
            r_idx <= '0;
            r_cnt <= '0;
        end else if (w_capture) begin
            for (int k = 0; k < NN; k++) begin
                r_buf[k] <= w_entry[k];
            end
            r_max <= w_entry[0];
            r_idx <= '0;
            r_cnt <= indexWidth'(1);
        end else if (r_state == SCAN) begin
            if (w_greater) begin
                r_max <= w_cand;
                r_idx <= r_cnt;
            end
            r_cnt <= r_cnt + indexWidth'(1);
        end
    end

    // Result register: loaded on the first DONE cycle, held until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_index    <= '0;
            r_maxValue <= '0;
        end else if (r_state == DONE) begin
            if (w_handshake) begin
                r_valid <= 1'b0;
            end else if (!r_valid) begin
                r_valid    <= 1'b1;
                r_index    <= r_idx;
                r_maxValue <= r_max;
            end
        end
    end

    // One-cycle drop pulse for every ignored i_valid cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_ignore;
        end
    end

    assign o_valid    = r_valid;
    assign o_index    = r_index;
    assign o_maxValue = r_maxValue;
    assign busy       = r_busy;
    assign drop       = r_drop;

endmodule
